// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package ifq_pkg;

    localparam int unsigned IFQ_XLEN = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam logic [IFQ_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] ins;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Registered FIFO holding fetched {pc, ins} entries; flush wins over push/pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = ifq_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and count update; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: streams PCs to imem and buffers responses for decode.
module if_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned     XLEN            = IFQ_XLEN,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   id_valid,
    output logic [XLEN-1:0]        id_pc,
    output logic [XLEN-1:0]        id_ins,
    input  logic                   id_ready,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } entry_t;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [SUM_W-1:0] inflight_sum;
    logic [XLEN-1:0]  target_pc;
    logic             grant;
    logic             drop_resp;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             unused_pc_bits;
    entry_t           push_entry;
    entry_t           head_entry;

    assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Queue space is reserved at issue time, so the sum counts entries plus requests in flight.
    assign inflight_sum = {1'b0, occupancy} + {1'b0, outstanding_q};
    assign imem_req     = rst && !redirect
                          && (inflight_sum < SUM_W'(DEPTH))
                          && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign imem_addr    = fetch_pc_q;
    assign grant        = imem_req && imem_gnt;

    assign drop_resp = imem_rvalid && (drop_cnt_q != '0);
    assign push      = imem_rvalid && !drop_resp && !redirect;
    assign pop       = id_valid && id_ready && !redirect;

    assign push_entry.pc  = resp_pc_q;
    assign push_entry.ins = imem_rdata;

    assign id_valid = !fifo_empty;
    assign id_pc    = head_entry.pc;
    assign id_ins   = head_entry.ins;

    ifq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .head_o  (head_entry),
        .count_o (occupancy),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Next-state for PCs and counters; on redirect every in-flight response belongs to the
    // abandoned stream, less the one being discarded in this very cycle.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            drop_cnt_d = outstanding_q - CNT_W'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + STEP;
            end
            if (drop_resp) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers; reset abandons anything still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Structural invariants of the reservation scheme.
    assert property (@(posedge clk) disable iff (!rst)
        outstanding_q <= CNT_W'(MAX_OUTSTANDING));
    assert property (@(posedge clk) disable iff (!rst)
        drop_cnt_q <= outstanding_q);
    assert property (@(posedge clk) disable iff (!rst)
        (inflight_sum - {1'b0, drop_cnt_q}) <= SUM_W'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full));
    assert property (@(posedge clk) disable iff (!rst)
        !(imem_rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue with a latency-configurable in-order memory.
module tb_if_prefetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } expEntry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pendEntry_t;

    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        idValid;
    logic [31:0] idPc;
    logic [31:0] idIns;
    logic        idReady;
    logic [2:0]  occupancy;

    int totalChecks = 0;
    int badChecks   = 0;
    int cyc         = 0;
    int grantCount  = 0;
    int memLat      = 1;

    expEntry_t  expQ[$];
    pendEntry_t pend[$];
    int         popCycles[$];

    if_prefetch_queue #(
        .XLEN            (32),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imemReq),
        .imem_addr   (imemAddr),
        .imem_gnt    (imemGnt),
        .imem_rvalid (imemRvalid),
        .imem_rdata  (imemRdata),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .id_valid    (idValid),
        .id_pc       (idPc),
        .id_ins      (idIns),
        .id_ready    (idReady),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic ready);
        redirect   = redir;
        redirectPc = rpc;
        idReady    = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expectPc(input logic [31:0] pc);
        expQ.push_back('{pc: pc, ins: memData(pc)});
    endtask

    task automatic expectRun(input logic [31:0] startPc, input int n);
        for (int i = 0; i < n; i++) begin
            expectPc(startPc + 32'(4 * i));
        end
    endtask

    task automatic waitDrain(input string name, input int budget);
        int left;
        left = budget;
        while (expQ.size() != 0 && left > 0) begin
            tick();
            left--;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // In-order memory: grant sampled on the edge, response presented memLat edges later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend.delete();
            imemRvalid = 1'b0;
        end else begin
            cyc++;
            if (imemReq && imemGnt) begin
                grantCount++;
                pend.push_back('{addr: imemAddr, due: cyc + memLat});
            end
            #1;
            if (rst && pend.size() > 0 && pend[0].due == cyc + 1) begin
                imemRvalid = 1'b1;
                imemRdata  = memData(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imemRvalid = 1'b0;
            end
        end
    end

    // Monitor: every accepted head is compared against the next expected entry.
    always @(negedge clk) begin
        expEntry_t e;
        if (rst && idValid && idReady && !redirect && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("id_pc", idPc, e.pc);
            checkOutput("id_ins", idIns, e.ins);
            popCycles.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g0;
        int p0;
        int left;
        int expDrop;
        bit found;

        rst        = 1'b0;
        imemGnt    = 1'b1;
        imemRdata  = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Test 1: reset values, then streaming with 1-cycle memory
        $display("[TB] test 1: streaming");
        tick();
        tick();
        checkOutput("rst_imem_req", 32'(imemReq), 32'd0);
        checkOutput("rst_id_valid", 32'(idValid), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        memLat = 1;
        p0 = popCycles.size();
        expectRun(32'h0000_3000, 8);
        rst = 1'b1;
        waitDrain("t1_drain", 60);
        if (popCycles.size() >= p0 + 8) begin
            checkOutput("t1_throughput", 32'(popCycles[p0 + 7] - popCycles[p0]), 32'd7);
        end else begin
            checkOutput("t1_pop_count", 32'(popCycles.size() - p0), 32'd8);
        end

        // Test 2: decode stalled fills exactly DEPTH entries
        $display("[TB] test 2: backpressure");
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        g0  = grantCount;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checkOutput("t2_grants", 32'(grantCount - g0), 32'd4);
        checkOutput("t2_imem_req", 32'(imemReq), 32'd0);
        checkOutput("t2_occupancy", 32'(occupancy), 32'd4);
        checkOutput("t2_head_pc", idPc, 32'h0000_3000);
        tick();
        tick();
        checkOutput("t2_head_stable", idPc, 32'h0000_3000);
        expectRun(32'h0000_3000, 6);
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitDrain("t2_drain", 60);
        checkOutput("t2_resumed", 32'(grantCount - g0 > 4), 32'd1);

        // Test 3: redirect with two requests in flight, latency 3
        $display("[TB] test 3: redirect drops late responses");
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        memLat = 3;
        g0  = grantCount;
        rst = 1'b1;
        left = 10;
        while (grantCount - g0 < 2 && left > 0) begin
            tick();
            left--;
        end
        checkOutput("t3_two_grants", 32'(grantCount - g0), 32'd2);
        checkOutput("t3_max_out_req", 32'(imemReq), 32'd0);
        applyStimulus(1'b1, 32'h0000_4002, 1'b0);
        #1;
        checkOutput("t3_redir_req", 32'(imemReq), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        checkOutput("t3_id_valid", 32'(idValid), 32'd0);
        expectRun(32'h0000_4000, 4);
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitDrain("t3_drain", 60);

        // Test 4: redirect coinciding with a response and a pop
        $display("[TB] test 4: redirect with rvalid and pop");
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        rst   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (idValid && imemRvalid && pend.size() >= 1) found = 1'b1;
        end
        checkOutput("t4_found", 32'(found), 32'd1);
        expDrop = pend.size();
        applyStimulus(1'b1, 32'h0000_5000, 1'b1);
        #1;
        checkOutput("t4_redir_req", 32'(imemReq), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t4_id_valid", 32'(idValid), 32'd0);
        checkOutput("t4_occupancy", 32'(occupancy), 32'd0);
        checkOutput("t4_drop_cnt", 32'(dut.drop_cnt_q), 32'(expDrop));
        expectRun(32'h0000_5000, 3);
        waitDrain("t4_drain", 60);

        // Test 5: back-to-back redirects, then PC wrap past the top of memory
        $display("[TB] test 5: back-to-back redirect and wrap");
        applyStimulus(1'b1, 32'h0000_6000, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t5_id_valid", 32'(idValid), 32'd0);
        expectPc(32'hFFFF_FFF8);
        expectPc(32'hFFFF_FFFC);
        expectPc(32'h0000_0000);
        expectPc(32'h0000_0004);
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitDrain("t5_drain", 60);

        // Test 6: asynchronous reset mid-stream with two requests in flight
        $display("[TB] test 6: async reset mid-stream");
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (pend.size() == 2) found = 1'b1;
        end
        checkOutput("t6_two_out", 32'(pend.size()), 32'd2);
        rst = 1'b0;
        #1;
        checkOutput("t6_imem_req", 32'(imemReq), 32'd0);
        checkOutput("t6_id_valid", 32'(idValid), 32'd0);
        checkOutput("t6_occupancy", 32'(occupancy), 32'd0);
        tick();
        tick();
        expectRun(32'h0000_3000, 3);
        rst = 1'b1;
        waitDrain("t6_drain", 60);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
